// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - multi-cycle IEEE-754 divider (binary32 / binary16) built on a reciprocal unit
//
// Computes out = a / b. The divisor mantissa is normalised and fed to recip_fp.
// The dividend mantissa is then multiplied by the reciprocal mantissa using a
// 1-bit/cycle shift-add multiplier. The product is normalised and packed.
//
// Ports (fdiv_seq):
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid        operands valid
//   in_ready        idle, can accept operands
//   a_bits, b_bits  dividend, divisor (TYPE bits)
//   out_valid       result valid, held until out_ready
//   out_ready       consumer accepts result
//   out_bits        quotient (TYPE bits)
//   except_flags    [0] inexact [1] underflow [2] overflow [3] div-by-zero [4] invalid
//
// Ports (recip_fp), combinational, normal positive inputs only:
//   x_exp, x_frac   biased exponent and fraction of x
//   y_exp, y_frac   biased exponent and fraction of 1/x (fraction truncated)

module recip_fp #(
  parameter int EXP  = 8,
  parameter int FRAC = 23,
  parameter int BIAS = 127
) (
  input  logic [EXP-1:0]  x_exp,
  input  logic [FRAC-1:0] x_frac,
  output logic [EXP-1:0]  y_exp,
  output logic [FRAC-1:0] y_frac
);
  localparam int MW = FRAC + 1;

  logic [2*MW-1:0] num;
  logic [2*MW-1:0] den;

  // For mantissa m in (1,2), 2^(2*FRAC+1)/m lands in (2^FRAC, 2^(FRAC+1)),
  // i.e. a normalised mantissa of 1/m one binade down.
  always_comb begin
    num = (2*MW)'(1) << (2*FRAC + 1);
    den = (2*MW)'({1'b1, x_frac});
    if (x_frac == '0) begin
      y_exp  = EXP'(2*BIAS) - x_exp;
      y_frac = '0;
    end else begin
      y_exp  = EXP'(2*BIAS - 1) - x_exp;
      y_frac = FRAC'(num / den);
    end
  end
endmodule

module fdiv_seq #(
  parameter int TYPE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TYPE-1:0] a_bits,
  input  logic [TYPE-1:0] b_bits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TYPE-1:0] out_bits,
  output logic [4:0]      except_flags
);
  localparam int EXP  = (TYPE == 32) ? 8 : 5;
  localparam int FRAC = (TYPE == 32) ? 23 : 10;
  localparam int BIAS = (TYPE == 32) ? 127 : 15;
  localparam int MW   = FRAC + 1;
  localparam int PW   = 2 * MW;
  localparam int CW   = $clog2(MW);
  localparam logic signed [11:0] E_MAX = 12'((1 << EXP) - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_MUL, S_NORM, S_DONE} state_t;

  state_t state, state_nxt;

  logic [TYPE-1:0]    a_r, b_r;
  logic [MW-1:0]      ma, mr;
  logic [PW-1:0]      acc;
  logic [CW-1:0]      cnt;
  logic signed [11:0] exp_sum;
  logic               sign_r;

  // Leading-zero count over an MW-bit mantissa (MW when all zero).
  function automatic logic [5:0] lzc(input logic [MW-1:0] v);
    lzc = 6'(MW);
    for (int i = 0; i < MW; i++) begin
      if (v[i]) lzc = 6'(MW - 1 - i);
    end
  endfunction

  // Operand decode and normalisation (used in PREP)
  logic            sa, sb, sq;
  logic [EXP-1:0]  ea_f, eb_f;
  logic [FRAC-1:0] fa, fb;
  logic [MW-1:0]   ma_raw, mb_raw, ma_n;
  logic [5:0]      lz_a, lz_b;
  logic [FRAC-1:0] nb_frac;
  logic signed [11:0] exp_a, exp_b, er;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa, ea_f, fa} = a_r;
  assign {sb, eb_f, fb} = b_r;
  assign sq = sa ^ sb;

  assign a_zero = (ea_f == '0) && (fa == '0);
  assign b_zero = (eb_f == '0) && (fb == '0);
  assign a_inf  = (&ea_f) && (fa == '0);
  assign b_inf  = (&eb_f) && (fb == '0);
  assign a_nan  = (&ea_f) && (fa != '0);
  assign b_nan  = (&eb_f) && (fb != '0);

  assign ma_raw  = {|ea_f, fa};
  assign mb_raw  = {|eb_f, fb};
  assign lz_a    = lzc(ma_raw);
  assign lz_b    = lzc(mb_raw);
  assign ma_n    = ma_raw << lz_a;
  assign nb_frac = FRAC'(mb_raw << lz_b);
  assign exp_a   = (ea_f != '0) ? 12'(ea_f) - 12'(BIAS) : 12'(1 - BIAS) - 12'(lz_a);
  assign exp_b   = (eb_f != '0) ? 12'(eb_f) - 12'(BIAS) : 12'(1 - BIAS) - 12'(lz_b);

  // Reciprocal of b's mantissa placed at exponent 0, so it always lands in (0.5,1].
  logic [EXP-1:0]  r_exp;
  logic [FRAC-1:0] r_frac;

  recip_fp #(.EXP(EXP), .FRAC(FRAC), .BIAS(BIAS)) u_recip (
    .x_exp  (EXP'(BIAS)),
    .x_frac (nb_frac),
    .y_exp  (r_exp),
    .y_frac (r_frac)
  );

  assign er = (r_exp == EXP'(BIAS)) ? 12'sd0 : -12'sd1;

  // Special operands, in priority order
  logic            special;
  logic [TYPE-1:0] spec_bits;
  logic [4:0]      spec_flags;
  localparam logic [TYPE-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};

  always_comb begin
    special    = 1'b1;
    spec_bits  = '0;
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_bits  = QNAN;
      spec_flags = 5'b10000;
    end else if (a_inf) begin
      spec_bits = {sq, {EXP{1'b1}}, {FRAC{1'b0}}};
    end else if (b_inf) begin
      spec_bits = {sq, {(TYPE-1){1'b0}}};
    end else if (b_zero) begin
      spec_bits  = {sq, {EXP{1'b1}}, {FRAC{1'b0}}};
      spec_flags = 5'b01000;
    end else if (a_zero) begin
      spec_bits = {sq, {(TYPE-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Normalise and pack (used in NORM). The product of two [1,2) mantissas,
  // scaled by 2^-(2*FRAC), lies in [1,4); a set MSB means the [2,4) binade.
  logic               p_msb, sticky;
  logic [FRAC-1:0]    q_frac;
  logic signed [11:0] e_res;
  logic [TYPE-1:0]    norm_bits;
  logic [4:0]         norm_flags;

  assign p_msb  = acc[PW-1];
  assign q_frac = p_msb ? acc[PW-2:MW] : acc[PW-3:MW-1];
  assign sticky = p_msb ? |acc[MW-1:0] : |acc[MW-2:0];
  assign e_res  = exp_sum + (p_msb ? 12'sd1 : 12'sd0) + 12'(BIAS);

  always_comb begin
    norm_bits  = {sign_r, e_res[EXP-1:0], q_frac};
    // The reciprocal is truncated, so the quotient is treated as inexact even
    // when no product bits are dropped.
    norm_flags = {4'b0000, sticky | 1'b1};
    if (e_res >= E_MAX) begin
      norm_bits  = {sign_r, {EXP{1'b1}}, {FRAC{1'b0}}};
      norm_flags = 5'b00101;
    end else if (e_res <= 12'sd0) begin
      norm_bits  = {sign_r, {(TYPE-1){1'b0}}};
      norm_flags = 5'b00011;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_PREP;
      S_PREP: state_nxt = special ? S_DONE : S_MUL;
      S_MUL:  if (cnt == CW'(MW - 1)) state_nxt = S_NORM;
      S_NORM: state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready  = 1'b1;
      S_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r          <= '0;
      b_r          <= '0;
      ma           <= '0;
      mr           <= '0;
      acc          <= '0;
      cnt          <= '0;
      exp_sum      <= '0;
      sign_r       <= 1'b0;
      out_bits     <= '0;
      except_flags <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r <= a_bits;
            b_r <= b_bits;
          end
        end
        S_PREP: begin
          sign_r  <= sq;
          ma      <= ma_n;
          mr      <= {1'b1, r_frac};
          exp_sum <= exp_a - exp_b + er;
          acc     <= '0;
          cnt     <= '0;
          if (special) begin
            out_bits     <= spec_bits;
            except_flags <= spec_flags;
          end
        end
        S_MUL: begin
          if (mr[0]) acc <= acc + (PW'(ma) << cnt);
          mr  <= mr >> 1;
          cnt <= cnt + CW'(1);
        end
        S_NORM: begin
          out_bits     <= norm_bits;
          except_flags <= norm_flags;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - directed self-checking bench for fdiv_seq (binary32)

module tb_fdiv_seq;
  localparam int MW       = 24;
  localparam int LAT_NORM = MW + 3;
  localparam int LAT_SPEC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_bits = '0;
  logic [31:0] b_bits = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_bits;
  logic [4:0]  except_flags;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fdiv_seq #(.TYPE(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_bits       (a_bits),
    .b_bits       (b_bits),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bits     (out_bits),
    .except_flags (except_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present one operand pair, then count cycles from the accept edge until out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    a_bits   = a;
    b_bits   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  localparam int NV = 13;
  logic [31:0] va [NV] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F000000,
                           32'h00800000, 32'h00400000, 32'h3F800000, 32'h7F000000,
                           32'hFF800000, 32'h3FC00000, 32'h80000000, 32'h7FC00000,
                           32'h3F800000};
  logic [31:0] vb [NV] = '{32'h00000000, 32'h80000000, 32'hFF800000, 32'h00800000,
                           32'h7F000000, 32'h3F000000, 32'h00400000, 32'h3F800000,
                           32'h40000000, 32'hFF800000, 32'h40000000, 32'h3F800000,
                           32'hFFC00001};
  logic [31:0] vq [NV] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
                           32'h00000000, 32'h00800000, 32'h7F000000, 32'h7F000000,
                           32'hFF800000, 32'h80000000, 32'h80000000, 32'h7FC00000,
                           32'h7FC00000};
  logic [4:0]  vf [NV] = '{5'b01000, 5'b10000, 5'b10000, 5'b00101,
                           5'b00011, 5'b00001, 5'b00001, 5'b00001,
                           5'b00000, 5'b00000, 5'b00000, 5'b10000,
                           5'b10000};
  int          vl [NV] = '{LAT_SPEC, LAT_SPEC, LAT_SPEC, LAT_NORM,
                           LAT_NORM, LAT_NORM, LAT_NORM, LAT_NORM,
                           LAT_SPEC, LAT_SPEC, LAT_SPEC, LAT_SPEC,
                           LAT_SPEC};
  string       vn [NV] = '{"one_div_zero", "zero_div_zero", "inf_div_inf", "overflow",
                           "underflow", "subnorm_a", "subnorm_b", "max_exp",
                           "inf_div_fin", "fin_div_inf", "zero_div_fin", "nan_a",
                           "nan_b"};

  initial begin
    int lat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_bits", out_bits, 32'h0);
    check("rst_flags", {27'b0, except_flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 6 / 2
    run_op(32'h40C00000, 32'h40000000, lat);
    check("div6_2_lat", lat, LAT_NORM);
    check("div6_2_bits", {31'b0, (out_bits == 32'h40400000) || (out_bits == 32'h403FFFFF)}, 32'd1);
    check("div6_2_flags", {27'b0, except_flags}, 32'h01);
    release_out();

    // Directed table
    for (int i = 0; i < NV; i++) begin
      run_op(va[i], vb[i], lat);
      check({vn[i], "_lat"}, lat, vl[i]);
      check({vn[i], "_bits"}, out_bits, vq[i]);
      check({vn[i], "_flags"}, {27'b0, except_flags}, {27'b0, vf[i]});
      release_out();
    end

    // Backpressure: hold out_ready low with new operands offered
    run_op(32'h3F800000, 32'h00000000, lat);
    @(negedge clk);
    a_bits   = 32'h40C00000;
    b_bits   = 32'h40000000;
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("hold_out_valid", {31'b0, out_valid}, 32'd1);
    check("hold_bits", out_bits, 32'h7F800000);
    check("hold_flags", {27'b0, except_flags}, 32'h08);
    check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);
    check("rel_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rel_no_ghost_op", {31'b0, out_valid}, 32'd0);

    // Reset during MUL aborts the operation
    @(negedge clk);
    a_bits   = 32'h40C00000;
    b_bits   = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid_after", {31'b0, out_valid}, 32'd0);

    // -10 / 5
    run_op(32'hC1200000, 32'h40A00000, lat);
    check("div10_5_lat", lat, LAT_NORM);
    check("div10_5_bits", {31'b0, (out_bits == 32'hC0000000) || (out_bits == 32'hBFFFFFFF)}, 32'd1);
    check("div10_5_flags", {27'b0, except_flags}, 32'h01);
    release_out();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
